// File: rtl/if_id_skid_stage_pkg.sv
// Shared constants and state encoding for the IF->ID skid-buffer stage.
package if_id_skid_stage_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/if_id_skid_stage_ctrl.sv
// Occupancy FSM for the skid buffer: registered in_ready and load enables for the entries.
module if_id_skid_ctrl
  import if_id_skid_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic m_valid,
  output logic m_load,
  output logic m_from_s,
  output logic s_load,
  output logic clear
);

  skid_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        acc, dep;

  assign m_valid = (state_q != ST_EMPTY);
  assign acc     = in_valid & in_ready_q;
  assign dep     = m_valid & out_ready;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      ST_EMPTY: if (acc) begin
        m_load  = 1'b1;
        state_d = ST_ONE;
      end
      ST_ONE: begin
        if (acc && dep) begin
          m_load = 1'b1;
        end else if (acc) begin
          s_load  = 1'b1;
          state_d = ST_FULL;
        end else if (dep) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (dep) begin
        m_load   = 1'b1;
        m_from_s = 1'b1;
        state_d  = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Kill overrides any accept/depart decided above.
    if (flush || !rst_n) begin
      state_d = ST_EMPTY;
      m_load  = 1'b0;
      s_load  = 1'b0;
      clear   = 1'b1;
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;

endmodule

// File: rtl/if_id_skid_stage_dff_en.sv
// Enable-gated register with a synchronous clear to a fixed value.
module dff_en #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr)     q_d = RST_VAL;
    else if (en) q_d = d;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline boundary: 2-entry skid buffer so ID back-pressure never reaches IF combinationally.
module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int                     ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                     DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEF),
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr
);

  logic                  m_valid, m_load, m_from_s, s_load, clear;
  logic [ADDR_WIDTH-1:0] m_pc, s_pc, m_pc_in;
  logic [DATA_WIDTH-1:0] m_instr, s_instr, m_instr_in;

  if_id_skid_ctrl u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .m_valid  (m_valid),
    .m_load   (m_load),
    .m_from_s (m_from_s),
    .s_load   (s_load),
    .clear    (clear)
  );

  // The skid entry always refills main first, so ordering is preserved.
  assign m_pc_in    = m_from_s ? s_pc    : in_pc;
  assign m_instr_in = m_from_s ? s_instr : in_instr;

  // NOTE: data registers are reset too, so outputs after reset/flush are deterministic.
  dff_en #(.W(ADDR_WIDTH), .RST_VAL(RESET_PC)) u_m_pc (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(m_load), .d(m_pc_in), .q(m_pc));
  dff_en #(.W(DATA_WIDTH), .RST_VAL(NOP_INSTR)) u_m_instr (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(m_load), .d(m_instr_in), .q(m_instr));
  dff_en #(.W(ADDR_WIDTH), .RST_VAL(RESET_PC)) u_s_pc (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(s_load), .d(in_pc), .q(s_pc));
  dff_en #(.W(DATA_WIDTH), .RST_VAL(NOP_INSTR)) u_s_instr (
    .clk(clk), .rst_n(rst_n), .clr(clear), .en(s_load), .d(in_instr), .q(s_instr));

  assign out_valid = m_valid;
  assign out_pc    = m_valid ? m_pc    : RESET_PC;
  assign out_instr = m_valid ? m_instr : NOP_INSTR;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: streaming, back-pressure, flush, reset and hold stability.
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ {pc[15:0], pc[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  task automatic expect_live(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, instr_of(pc));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_pc"}, out_pc, 32'h0);
    check({tag, "_instr"}, out_instr, NOP);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic fill(input logic [31:0] pc0, input logic [31:0] pc1);
    out_ready = 1'b0;
    push(1'b1, pc0); tick();
    push(1'b1, pc1); tick();
    push(1'b0, 32'h0);
    check("fill_full_ready", 32'(in_ready), 32'd0);
    check("fill_head_pc", out_pc, pc0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    push(1'b0, 32'h0);
    tick(); tick();
    expect_idle("reset");
    rst_n = 1'b1;

    // 2. streaming
    out_ready = 1'b1;
    push(1'b1, 32'h0); tick(); expect_live("stream0", 32'h0);
    check("stream0_rdy", 32'(in_ready), 32'd1);
    push(1'b1, 32'h4); tick(); expect_live("stream4", 32'h4);
    check("stream4_rdy", 32'(in_ready), 32'd1);
    push(1'b1, 32'h8); tick(); expect_live("stream8", 32'h8);
    check("stream8_rdy", 32'(in_ready), 32'd1);
    push(1'b0, 32'h0); tick(); expect_idle("stream_drain");

    // 3. back-pressure
    out_ready = 1'b0;
    push(1'b1, 32'h10); tick(); expect_live("bp_one", 32'h10);
    check("bp_one_rdy", 32'(in_ready), 32'd1);
    push(1'b1, 32'h14); tick(); expect_live("bp_full", 32'h10);
    check("bp_full_rdy", 32'(in_ready), 32'd0);
    push(1'b1, 32'h18); tick(); expect_live("bp_hold", 32'h10);
    check("bp_hold_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick(); expect_live("bp_out14", 32'h14);
    check("bp_out14_rdy", 32'(in_ready), 32'd1);
    tick(); expect_live("bp_out18", 32'h18);
    push(1'b0, 32'h0); tick(); expect_idle("bp_drain");

    // 4. flush while FULL with in_valid, then flush in ONE with a same-cycle accept
    fill(32'h30, 32'h34);
    push(1'b1, 32'h20); flush = 1'b1; tick();
    flush = 1'b0; push(1'b0, 32'h0);
    expect_idle("flush_full");
    out_ready = 1'b1; tick();
    expect_idle("flush_full_after");
    out_ready = 1'b0;
    push(1'b1, 32'h40); tick(); expect_live("flush_one_pre", 32'h40);
    push(1'b1, 32'h44); flush = 1'b1; out_ready = 1'b1; tick();
    flush = 1'b0; push(1'b0, 32'h0);
    expect_idle("flush_one");
    tick(); expect_idle("flush_one_after");

    // 5. mid-op reset, then reset together with flush
    fill(32'h50, 32'h54);
    rst_n = 1'b0; tick(); expect_idle("rst_full");
    rst_n = 1'b1; out_ready = 1'b1; tick(); expect_idle("rst_full_after");
    fill(32'h60, 32'h64);
    rst_n = 1'b0; flush = 1'b1; tick(); expect_idle("rst_flush");
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1; tick(); expect_idle("rst_flush_after");

    // 6. stability under back-pressure with random upstream traffic
    out_ready = 1'b0;
    push(1'b1, 32'h70); tick(); expect_live("stable_load", 32'h70);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_pc    = $urandom;
      in_instr = $urandom;
      tick();
      expect_live("stable_hold", 32'h70);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
